// File: rtl/spiflash_rd_arb.sv
// Two-port burst-read sequencer/arbiter for an external SPI NOR flash (fast read or quad output read).
// Optional feature macro: SPIFLASH_QUAD_EN selects quad output read (0x6B) with 4-bit data lanes.
`timescale 1ns/1ps
module spiflash_rd_arb #(
  parameter int LEN_W = 8,
  parameter int DUMMY = 8,
  parameter int CS_HI = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [23:0]      addr0,
  input  logic [LEN_W-1:0] len0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [23:0]      addr1,
  input  logic [LEN_W-1:0] len1,
  output logic             gnt1,
  output logic [7:0]       rdata,
  output logic             rvalid,
  output logic             rsel,
  output logic             done,
  output logic             busy,
  output logic             sclk,
  output logic             cs_n,
  output logic [3:0]       qdo,
  input  logic [3:0]       qdi,
  output logic [3:0]       oe
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_GAP
  } state_t;

  state_t           state_reg;
  logic             last_served_reg;
  logic [31:0]      sh_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] byte_cnt_reg;
  logic [15:0]      cnt_reg;
  logic [2:0]       sub_cnt_reg;
  logic [7:0]       rx_reg;
  logic [7:0]       rx_next;
  logic             pick1;
  logic             unused_bits;

`ifdef SPIFLASH_QUAD_EN
  localparam logic [7:0] RD_CMD   = 8'h6B;
  localparam logic [2:0] SUB_LAST = 3'd1;
  assign rx_next     = {rx_reg[3:0], qdi};
  assign unused_bits = ^rx_reg[7:4];
`else
  localparam logic [7:0] RD_CMD   = 8'h0B;
  localparam logic [2:0] SUB_LAST = 3'd7;
  assign rx_next     = {rx_reg[6:0], qdi[1]};
  assign unused_bits = ^{rx_reg[7], qdi[3:2], qdi[0]};
`endif

  // On contention the port not served last wins; a lone request always wins.
  assign pick1 = req1 && (!req0 || !last_served_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      last_served_reg <= 1'b1;
      sh_reg          <= '0;
      len_reg         <= '0;
      byte_cnt_reg    <= '0;
      cnt_reg         <= '0;
      sub_cnt_reg     <= '0;
      rx_reg          <= '0;
      gnt0            <= 1'b0;
      gnt1            <= 1'b0;
      rdata           <= '0;
      rvalid          <= 1'b0;
      rsel            <= 1'b0;
      done            <= 1'b0;
      busy            <= 1'b0;
      sclk            <= 1'b0;
      cs_n            <= 1'b1;
      qdo             <= '0;
      oe              <= '0;
    end else begin
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      rvalid <= 1'b0;
      done   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (req0 || req1) begin
            busy         <= 1'b1;
            state_reg    <= S_GRANT;
            byte_cnt_reg <= '0;
            sub_cnt_reg  <= '0;
            if (pick1) begin
              gnt1            <= 1'b1;
              rsel            <= 1'b1;
              last_served_reg <= 1'b1;
              sh_reg          <= {RD_CMD, addr1};
              len_reg         <= len1;
            end else begin
              gnt0            <= 1'b1;
              rsel            <= 1'b0;
              last_served_reg <= 1'b0;
              sh_reg          <= {RD_CMD, addr0};
              len_reg         <= len0;
            end
          end
        end
        // Setup cycle: chip select asserted with the first command bit, sclk still low.
        S_GRANT: begin
          cs_n      <= 1'b0;
          oe        <= 4'b0001;
          qdo       <= {3'b000, sh_reg[31]};
          sh_reg    <= {sh_reg[30:0], 1'b0};
          cnt_reg   <= '0;
          state_reg <= S_CMD;
        end
        S_CMD, S_ADDR: begin
          sclk <= ~sclk;
          if (sclk) begin
            qdo     <= {3'b000, sh_reg[31]};
            sh_reg  <= {sh_reg[30:0], 1'b0};
            cnt_reg <= cnt_reg + 16'd1;
            if (state_reg == S_CMD && cnt_reg == 16'd7) begin
              state_reg <= S_ADDR;
              cnt_reg   <= '0;
            end else if (state_reg == S_ADDR && cnt_reg == 16'd23) begin
              cnt_reg <= '0;
              qdo     <= '0;
              if (DUMMY == 0) begin
                state_reg <= S_DATA;
                oe        <= '0;
              end else begin
                state_reg <= S_DUMMY;
              end
            end
          end
        end
        S_DUMMY: begin
          sclk <= ~sclk;
          if (sclk) begin
            cnt_reg <= cnt_reg + 16'd1;
            if (cnt_reg == 16'(DUMMY - 1)) begin
              state_reg <= S_DATA;
              oe        <= '0;
              cnt_reg   <= '0;
            end
          end
        end
        // qdi is sampled on the clk edge that drops sclk, i.e. the end of each bit period.
        S_DATA: begin
          sclk <= ~sclk;
          if (sclk) begin
            rx_reg      <= rx_next;
            sub_cnt_reg <= sub_cnt_reg + 3'd1;
            if (sub_cnt_reg == SUB_LAST) begin
              sub_cnt_reg <= '0;
              rdata       <= rx_next;
              rvalid      <= 1'b1;
              if (byte_cnt_reg == len_reg) begin
                done      <= 1'b1;
                cs_n      <= 1'b1;
                oe        <= '0;
                cnt_reg   <= '0;
                state_reg <= S_GAP;
              end else begin
                byte_cnt_reg <= byte_cnt_reg + 1'b1;
              end
            end
          end
        end
        S_GAP: begin
          cnt_reg <= cnt_reg + 16'd1;
          if (cnt_reg == 16'(CS_HI - 1)) begin
            state_reg <= S_IDLE;
            busy      <= 1'b0;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spiflash_rd_arb.sv
// Directed bench for spiflash_rd_arb with a behavioural SPI flash holding 0x00,0x11,..,0xFF at 0x0..0xF.
`timescale 1ns/1ps
module tb_spiflash_rd_arb;
  localparam int LEN_W = 8;
  localparam int DUMMY = 8;
  localparam int CS_HI = 4;
`ifdef SPIFLASH_QUAD_EN
  localparam logic [7:0] EXP_CMD = 8'h6B;
  localparam int SCLK_PER_BYTE = 2;
  localparam int RISES_LEN3 = 48;
`else
  localparam logic [7:0] EXP_CMD = 8'h0B;
  localparam int SCLK_PER_BYTE = 8;
  localparam int RISES_LEN3 = 72;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [23:0] addr0 = '0, addr1 = '0;
  logic [LEN_W-1:0] len0 = '0, len1 = '0;
  logic gnt0, gnt1, rvalid, rsel, done, busy, sclk, cs_n;
  logic [7:0] rdata;
  logic [3:0] qdo, oe;
  logic [3:0] qdi = 4'h0;

  int n_checks = 0;
  int n_fail = 0;

  spiflash_rd_arb #(.LEN_W(LEN_W), .DUMMY(DUMMY), .CS_HI(CS_HI)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .len0(len0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .len1(len1), .gnt1(gnt1),
    .rdata(rdata), .rvalid(rvalid), .rsel(rsel), .done(done), .busy(busy),
    .sclk(sclk), .cs_n(cs_n), .qdo(qdo), .qdi(qdi), .oe(oe)
  );

  always #5 clk = ~clk;

  // ---------------- flash model ----------------
  int rises = 0, falls = 0, last_rises = 0;
  logic [7:0]  f_cmd = '0, last_cmd = '0;
  logic [23:0] f_addr = '0, last_addr = '0;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    logic [3:0] v;
    v = a[3:0];
    return {v, v};
  endfunction

  always @(posedge sclk or negedge sclk or posedge cs_n) begin
    int d;
    logic [7:0] b;
    if (cs_n === 1'b1) begin
      if (rises != 0) begin
        last_rises = rises;
        last_cmd   = f_cmd;
        last_addr  = f_addr;
      end
      rises = 0;
      falls = 0;
      qdi   = 4'h0;
    end else if (sclk === 1'b1) begin
      if (rises < 8) f_cmd = {f_cmd[6:0], qdo[0]};
      else if (rises < 32) f_addr = {f_addr[22:0], qdo[0]};
      rises++;
    end else begin
      falls++;
      if (falls >= 32 + DUMMY) begin
        d = falls - 32 - DUMMY;
`ifdef SPIFLASH_QUAD_EN
        b   = mem_byte(f_addr + 24'(d / 2));
        qdi = (d % 2 == 0) ? b[7:4] : b[3:0];
`else
        b   = mem_byte(f_addr + 24'(d / 8));
        qdi = {2'b00, b[3'(7 - (d % 8))], 1'b0};
`endif
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [7:0] rx_q[$];
  logic       rsel_q[$];
  int   done_cnt = 0;
  int   done_at = -1;
  logic done_rv = 1'b0;
  int   sclk_bad = 0;

  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      rx_q.push_back(rdata);
      rsel_q.push_back(rsel);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_at = rx_q.size();
      done_rv = rvalid;
    end
    if (sclk === 1'b1 && cs_n === 1'b1) sclk_bad++;
  end

  task automatic clear_mon();
    rx_q.delete();
    rsel_q.delete();
    done_cnt = 0;
    done_at  = -1;
    done_rv  = 1'b0;
  endtask

  task automatic wait_gnt(input int port, output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cyc++;
      if ((port == 0 && gnt0 === 1'b1) || (port == 1 && gnt1 === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_dones(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    req0  = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cs_n, sclk, qdo, oe} !== {1'b1, 1'b0, 4'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_pins: cs_n/sclk/qdo/oe got %b required %b", {cs_n, sclk, qdo, oe}, 10'b1000000000);
    end
    n_checks++;
    if ({gnt0, gnt1, rvalid, done, busy, rsel} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_flags: gnt0/gnt1/rvalid/done/busy/rsel got %b required 000000", {gnt0, gnt1, rvalid, done, busy, rsel});
    end
    n_checks++;
    if (rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h required 00", rdata);
    end
    req0 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_single_burst();
    bit ok;
    int cyc;
    logic [7:0] exp_d[4] = '{8'h44, 8'h55, 8'h66, 8'h77};
    clear_mon();
    addr0 = 24'h000004; len0 = 8'd3; req0 = 1'b1;
    wait_gnt(0, ok, cyc);
    req0 = 1'b0;
    n_checks++;
    if (ok !== 1'b1 || cyc != 1) begin
      n_fail++;
      $display("FAIL burst1_gnt_latency: got ok=%0d cycles=%0d required ok=1 cycles=1", ok, cyc);
    end
    n_checks++;
    if ({busy, rsel, gnt1} !== 3'b100) begin
      n_fail++;
      $display("FAIL burst1_at_gnt: busy/rsel/gnt1 got %b required 100", {busy, rsel, gnt1});
    end
    @(negedge clk);
    n_checks++;
    if ({gnt0, cs_n, sclk, oe} !== {1'b0, 1'b0, 1'b0, 4'b0001}) begin
      n_fail++;
      $display("FAIL burst1_setup: gnt0/cs_n/sclk/oe got %b required 0000001", {gnt0, cs_n, sclk, oe});
    end
    wait_dones(1, ok);
    n_checks++;
    if (ok !== 1'b1 || rx_q.size() != 4) begin
      n_fail++;
      $display("FAIL burst1_count: got done_ok=%0d bytes=%0d required done_ok=1 bytes=4", ok, rx_q.size());
    end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_d[i] || rsel_q[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL burst1_byte%0d: got %h rsel=%b required %h rsel=0", i, rx_q[i], rsel_q[i], exp_d[i]);
      end
    end
    n_checks++;
    if (done_at != 4 || done_rv !== 1'b1) begin
      n_fail++;
      $display("FAIL burst1_done_pos: got after byte %0d rvalid=%b required after byte 4 rvalid=1", done_at, done_rv);
    end
    n_checks++;
    if (last_cmd !== EXP_CMD || last_addr !== 24'h000004) begin
      n_fail++;
      $display("FAIL burst1_cmd_addr: got %h/%h required %h/000004", last_cmd, last_addr, EXP_CMD);
    end
    n_checks++;
    if (last_rises != RISES_LEN3) begin
      n_fail++;
      $display("FAIL burst1_sclk_rises: got %0d required %0d", last_rises, RISES_LEN3);
    end
    $display("test_single_burst done: %0d bytes", rx_q.size());
  endtask

  task automatic test_contention();
    bit ok;
    int cyc;
    int dc_at_gnt1;
    logic [7:0] exp_d[3] = '{8'h00, 8'h11, 8'hAA};
    logic       exp_s[3] = '{1'b0, 1'b0, 1'b1};
    do_reset();
    clear_mon();
    addr0 = 24'h000000; len0 = 8'd1;
    addr1 = 24'h00000A; len1 = 8'd0;
    req0 = 1'b1; req1 = 1'b1;
    wait_gnt(0, ok, cyc);
    req0 = 1'b0;
    n_checks++;
    if (ok !== 1'b1 || gnt1 !== 1'b0) begin
      n_fail++;
      $display("FAIL contend_first: got gnt0_ok=%0d gnt1=%b required gnt0_ok=1 gnt1=0", ok, gnt1);
    end
    wait_gnt(1, ok, cyc);
    req1 = 1'b0;
    #1;
    dc_at_gnt1 = done_cnt;
    n_checks++;
    if (ok !== 1'b1 || dc_at_gnt1 != 1) begin
      n_fail++;
      $display("FAIL contend_second_gnt: got ok=%0d dones_before=%0d required ok=1 dones_before=1", ok, dc_at_gnt1);
    end
    wait_dones(2, ok);
    n_checks++;
    if (ok !== 1'b1 || rx_q.size() != 3) begin
      n_fail++;
      $display("FAIL contend_count: got ok=%0d bytes=%0d required ok=1 bytes=3", ok, rx_q.size());
    end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_d[i] || rsel_q[i] !== exp_s[i]) begin
        n_fail++;
        $display("FAIL contend_byte%0d: got %h rsel=%b required %h rsel=%b", i, rx_q[i], rsel_q[i], exp_d[i], exp_s[i]);
      end
    end
    $display("test_contention done: %0d bytes", rx_q.size());
  endtask

  task automatic test_alternation();
    bit ok;
    int cyc;
    logic [7:0] exp_d[3] = '{8'h22, 8'h33, 8'h55};
    logic       exp_s[3] = '{1'b1, 1'b0, 1'b1};
    clear_mon();
    addr1 = 24'h000002; len1 = 8'd0; req1 = 1'b1;
    wait_gnt(1, ok, cyc);
    req1 = 1'b0;
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL alt_lone_req1: got ok=%0d required 1", ok);
    end
    repeat (5) @(negedge clk);
    addr0 = 24'h000003; len0 = 8'd0; req0 = 1'b1;
    addr1 = 24'h000005; len1 = 8'd0; req1 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (ok !== 1'b1 || {gnt0, gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL alt_winner: got ok=%0d gnt0/gnt1=%b required ok=1 gnt0/gnt1=10", ok, {gnt0, gnt1});
    end
    req0 = 1'b0;
    wait_gnt(1, ok, cyc);
    req1 = 1'b0;
    wait_dones(3, ok);
    n_checks++;
    if (ok !== 1'b1 || rx_q.size() != 3) begin
      n_fail++;
      $display("FAIL alt_count: got ok=%0d bytes=%0d required ok=1 bytes=3", ok, rx_q.size());
    end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_d[i] || rsel_q[i] !== exp_s[i]) begin
        n_fail++;
        $display("FAIL alt_byte%0d: got %h rsel=%b required %h rsel=%b", i, rx_q[i], rsel_q[i], exp_d[i], exp_s[i]);
      end
    end
    $display("test_alternation done: %0d bytes", rx_q.size());
  endtask

  task automatic test_single_byte();
    bit ok;
    int cyc;
    int hi_cnt;
    clear_mon();
    addr0 = 24'h00000F; len0 = 8'd0; req0 = 1'b1;
    wait_gnt(0, ok, cyc);
    req0 = 1'b0;
    wait_dones(1, ok);
    n_checks++;
    if (ok !== 1'b1 || rx_q.size() != 1 || done_at != 1 || done_rv !== 1'b1) begin
      n_fail++;
      $display("FAIL single_count: got ok=%0d bytes=%0d done_at=%0d rv=%b required 1/1/1/1", ok, rx_q.size(), done_at, done_rv);
    end
    if (rx_q.size() > 0) begin
      n_checks++;
      if (rx_q[0] !== 8'hFF) begin
        n_fail++;
        $display("FAIL single_data: got %h required ff", rx_q[0]);
      end
    end
    n_checks++;
    if ({busy, cs_n} !== 2'b11) begin
      n_fail++;
      $display("FAIL single_after_done: busy/cs_n got %b required 11", {busy, cs_n});
    end
    // Request immediately and count how long cs_n stays high before the next burst.
    addr0 = 24'h000000; len0 = 8'd0; req0 = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (cs_n !== 1'b1) break;
      hi_cnt++;
      @(negedge clk);
      if (gnt0 === 1'b1) req0 = 1'b0;
    end
    req0 = 1'b0;
    n_checks++;
    if (hi_cnt < CS_HI || hi_cnt >= 200) begin
      n_fail++;
      $display("FAIL single_cs_high: got %0d clk required >= %0d", hi_cnt, CS_HI);
    end
    wait_dones(2, ok);
    n_checks++;
    if (ok !== 1'b1 || rx_q.size() != 2) begin
      n_fail++;
      $display("FAIL single_followup: got ok=%0d bytes=%0d required ok=1 bytes=2", ok, rx_q.size());
    end
    $display("test_single_byte done: cs_n high %0d clk", hi_cnt);
  endtask

  task automatic test_reset_abort();
    bit ok;
    int cyc;
    logic [7:0] exp_d[2] = '{8'h88, 8'h99};
    clear_mon();
    addr0 = 24'h000004; len0 = 8'd3; req0 = 1'b1;
    wait_gnt(0, ok, cyc);
    req0 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rx_q.size() >= 1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ok !== 1'b1 || {cs_n, sclk, oe} !== {1'b1, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL abort_pins: got data_seen=%0d cs_n/sclk/oe=%b required 1 and 100000", ok, {cs_n, sclk, oe});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: got dones=%0d busy=%b required 0/0", done_cnt, busy);
    end
    clear_mon();
    addr0 = 24'h000008; len0 = 8'd1; req0 = 1'b1;
    wait_gnt(0, ok, cyc);
    req0 = 1'b0;
    wait_dones(1, ok);
    n_checks++;
    if (ok !== 1'b1 || rx_q.size() != 2) begin
      n_fail++;
      $display("FAIL abort_recover_count: got ok=%0d bytes=%0d required ok=1 bytes=2", ok, rx_q.size());
    end
    for (int i = 0; i < 2 && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL abort_recover_byte%0d: got %h required %h", i, rx_q[i], exp_d[i]);
      end
    end
    n_checks++;
    if (last_rises != 40 + 2 * SCLK_PER_BYTE) begin
      n_fail++;
      $display("FAIL abort_recover_rises: got %0d required %0d", last_rises, 40 + 2 * SCLK_PER_BYTE);
    end
    $display("test_reset_abort done: %0d bytes after recovery", rx_q.size());
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_contention();
    test_alternation();
    test_single_byte();
    test_reset_abort();
    n_checks++;
    if (sclk_bad != 0) begin
      n_fail++;
      $display("FAIL sclk_while_cs_high: got %0d clk required 0", sclk_bad);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
